// File: rtl/cpu_reg_writeback.sv
// Register-file writer: arbitrates ALU and load results onto the single write
// port, buffers loads in a small FIFO, and tracks outstanding loads per register.
module cpu_reg_writeback #(
  parameter logic        MORE_REGISTERS = 1'b1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        lsu_issue,
  input  logic [4:0]  lsu_issue_rd,
  output logic        lsu_issue_ready,
  output logic [31:0] busy,
  output logic [4:0]  addr_wr,
  output logic [31:0] data_wr,
  output logic        wr
);

  localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  function automatic logic dest_ok(input logic [4:0] rd);
    return (rd != 5'd0) && (MORE_REGISTERS || !rd[4]);
  endfunction

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic          mem_accept, alu_sel, pop, bypass, push;
  logic          sel_wr, sel_load;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          wr_load;

  logic [1:0]    cnt [32];
  logic [31:0]   inc_vec, dec_vec;

  // Ready depends only on the registered occupancy.
  assign mem_ready = (count != FULL_COUNT);

  // Arbitration: ALU first, then FIFO head, then direct load bypass.
  always_comb begin
    mem_accept = mem_valid && mem_ready;
    alu_sel    = alu_valid && dest_ok(alu_rd);
    pop        = !alu_sel && (count != '0);
    bypass     = !alu_sel && (count == '0) && mem_accept && dest_ok(mem_rd);
    // Invalid-destination loads are handshaken and dropped, never stored.
    push       = mem_accept && dest_ok(mem_rd) && !bypass;
    sel_wr     = 1'b0;
    sel_load   = 1'b0;
    sel_rd     = '0;
    sel_data   = '0;
    if (alu_sel) begin
      sel_wr   = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (pop) begin
      sel_wr   = 1'b1;
      sel_load = 1'b1;
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (bypass) begin
      sel_wr   = 1'b1;
      sel_load = 1'b1;
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end
  end

  // Registered write port; address/data hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr      <= 1'b0;
      wr_load <= 1'b0;
      addr_wr <= '0;
      data_wr <= '0;
    end else begin
      wr      <= sel_wr;
      wr_load <= sel_load;
      if (sel_wr) begin
        addr_wr <= sel_rd;
        data_wr <= sel_data;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage (contents are meaningless once pointers reset).
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Per-register increment on issue, decrement while a load write is on the port.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (lsu_issue && dest_ok(lsu_issue_rd) && (cnt[lsu_issue_rd] != 2'd3))
      inc_vec[lsu_issue_rd] = 1'b1;
    if (wr && wr_load)
      dec_vec[addr_wr] = 1'b1;
  end

  assign lsu_issue_ready = !dest_ok(lsu_issue_rd) || (cnt[lsu_issue_rd] != 2'd3);

  // busy already reflects the decrement of a load write visible this cycle.
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < 32; r++)
      busy[r] = (cnt[r] != 2'd0) && !(dec_vec[r] && (cnt[r] == 2'd1));
  end

  // Outstanding-load counters, saturating at 3, never below 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_reg_writeback.sv
// Directed test-plan steps followed by randomized traffic, all checked every
// cycle against a queue/array reference model of the writeback rules.
module tb_cpu_reg_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, lsu_issue;
  logic [4:0]  alu_rd, mem_rd, lsu_issue_rd;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, lsu_issue_ready, wr;
  logic [31:0] busy, data_wr;
  logic [4:0]  addr_wr;
  logic        mem_ready_s, lsu_issue_ready_s, wr_s;
  logic [31:0] busy_s, data_wr_s;
  logic [4:0]  addr_wr_s;

  always #5 clk = ~clk;

  cpu_reg_writeback #(.MORE_REGISTERS(1'b1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd), .lsu_issue_ready(lsu_issue_ready),
    .busy(busy), .addr_wr(addr_wr), .data_wr(data_wr), .wr(wr)
  );

  cpu_reg_writeback #(.MORE_REGISTERS(1'b0), .FIFO_DEPTH(DEPTH)) dut_small (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready_s),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd), .lsu_issue_ready(lsu_issue_ready_s),
    .busy(busy_s), .addr_wr(addr_wr_s), .data_wr(data_wr_s), .wr(wr_s)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Reference model: pending loads in order, outstanding count per register,
  // and the write currently expected on the port.
  ent_t        q[$];
  int          cnt[32];
  logic        m_wr, m_load;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_acc;

  function automatic bit vdest(input logic [4:0] r);
    return r != 5'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) begin
      int eff;
      eff = cnt[r] - ((m_wr && m_load && m_addr == 5'(r)) ? 1 : 0);
      b[r] = (eff > 0);
    end
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    m_wr = 0; m_load = 0; m_addr = '0; m_data = '0; m_acc = 0;
  endtask

  task automatic check_all();
    chk("wr", 32'(wr), 32'(m_wr));
    chk("addr_wr", 32'(addr_wr), 32'(m_addr));
    chk("data_wr", data_wr, m_data);
    chk("mem_ready", 32'(mem_ready), 32'(q.size() < DEPTH));
    chk("lsu_issue_ready", 32'(lsu_issue_ready), 32'(cnt[lsu_issue_rd] != 3));
    chk("busy", busy, model_busy());
  endtask

  task automatic model_next();
    bit   took, nwr, nload;
    ent_t e;
    m_acc = mem_valid && (q.size() < DEPTH);
    for (int r = 1; r < 32; r++) begin
      bit inc, dec;
      inc = lsu_issue && (lsu_issue_rd == 5'(r)) && (cnt[r] != 3);
      dec = m_wr && m_load && (m_addr == 5'(r));
      if (inc && !dec) cnt[r]++;
      else if (dec && !inc && cnt[r] > 0) cnt[r]--;
    end
    took = 0; nwr = 0; nload = 0;
    if (alu_valid && vdest(alu_rd)) begin
      nwr = 1; m_addr = alu_rd; m_data = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      nwr = 1; nload = 1; m_addr = e.rd; m_data = e.d;
    end else if (m_acc && vdest(mem_rd)) begin
      nwr = 1; nload = 1; m_addr = mem_rd; m_data = mem_data; took = 1;
    end
    if (m_acc && vdest(mem_rd) && !took) begin
      e.rd = mem_rd; e.d = mem_data;
      q.push_back(e);
    end
    m_wr = nwr; m_load = nload;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    lsu_issue = 0; lsu_issue_rd = '0;
  endtask

  // Inputs are set at the falling edge; check, advance model, move to next falling edge.
  task automatic cycle();
    #1 check_all();
    model_next();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    idle();
    rst = 1;
    #1;
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_issue_ready"}, 32'(lsu_issue_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int k;
    idle();
    model_reset();
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_addr", 32'(addr_wr), 32'd0);
    chk("rst_data", data_wr, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_small_ready", 32'(mem_ready_s), 32'd1);
    chk("rst_small_busy", busy_s, 32'd0);
    chk("rst_small_issue_ready", 32'(lsu_issue_ready_s), 32'd1);
    @(negedge clk);
    rst = 0;

    // 1: single ALU write
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    idle();
    chk("t1_wr", 32'(wr), 32'd1);
    chk("t1_addr", 32'(addr_wr), 32'd5);
    chk("t1_data", data_wr, 32'hDEADBEEF);
    cycle();
    chk("t1_wr_off", 32'(wr), 32'd0);
    chk("t1_busy", busy, 32'd0);

    // 2: issue then bypassed load
    lsu_issue = 1; lsu_issue_rd = 5'd7;
    cycle();
    idle();
    chk("t2_busy_set", 32'(busy[7]), 32'd1);
    cycle();
    cycle();
    mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h12345678;
    chk("t2_busy_held", 32'(busy[7]), 32'd1);
    cycle();
    idle();
    chk("t2_wr", 32'(wr), 32'd1);
    chk("t2_addr", 32'(addr_wr), 32'd7);
    chk("t2_data", data_wr, 32'h12345678);
    chk("t2_busy_clr", 32'(busy[7]), 32'd0);
    cycle();

    // 3: ALU hogs the port while loads fill the FIFO
    k = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'h100 + 32'(i);
      mem_valid = (k < 5); mem_rd = 5'(10 + k); mem_data = 32'hA0 + 32'(k);
      if (i == 4) chk("t3_full", 32'(mem_ready), 32'd0);
      cycle();
      if (mem_valid && m_acc) k++;
    end
    chk("t3_accepted", 32'(k), 32'd4);
    for (int j = 0; j < 5; j++) begin
      alu_valid = 0;
      mem_valid = (k < 5); mem_rd = 5'(10 + k); mem_data = 32'hA0 + 32'(k);
      cycle();
      if (mem_valid && m_acc) k++;
      chk("t3_order_wr", 32'(wr), 32'd1);
      chk("t3_order_addr", 32'(addr_wr), 32'(10 + j));
      chk("t3_order_data", data_wr, 32'hA0 + 32'(j));
    end
    idle();
    cycle();

    // 4: invalid destinations
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h0BAD;
    mem_valid = 1; mem_rd = 5'd0; mem_data = 32'h0BAD;
    chk("t4_ready", 32'(mem_ready), 32'd1);
    cycle();
    idle();
    chk("t4_r0_nowr", 32'(wr), 32'd0);
    chk("t4_r0_nowr_small", 32'(wr_s), 32'd0);
    alu_valid = 1; alu_rd = 5'd20; alu_data = 32'h20;
    cycle();
    idle();
    chk("t4_small_r20_nowr", 32'(wr_s), 32'd0);
    chk("t4_big_r20_wr", 32'(wr), 32'd1);
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    cycle();
    idle();
    chk("t4_small_r3_wr", 32'(wr_s), 32'd1);
    chk("t4_small_r3_addr", 32'(addr_wr_s), 32'd3);
    chk("t4_small_r3_data", data_wr_s, 32'h33);
    mem_valid = 1; mem_rd = 5'd20; mem_data = 32'h44;
    chk("t4_small_ready", 32'(mem_ready_s), 32'd1);
    cycle();
    idle();
    chk("t4_small_load20_nowr", 32'(wr_s), 32'd0);
    cycle();

    // 5: scoreboard saturation and same-cycle issue/retire
    for (int n = 0; n < 4; n++) begin
      lsu_issue = 1; lsu_issue_rd = 5'd9;
      chk("t5_issue_ready", 32'(lsu_issue_ready), 32'(n < 3));
      cycle();
    end
    idle();
    for (int l = 0; l < 3; l++) begin
      mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h900 + 32'(l);
      cycle();
      idle();
      chk("t5_busy9", 32'(busy[9]), 32'(l < 2));
      cycle();
    end
    lsu_issue = 1; lsu_issue_rd = 5'd9;
    cycle();
    idle();
    mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h999;
    cycle();
    idle();
    lsu_issue = 1; lsu_issue_rd = 5'd9;
    cycle();
    idle();
    chk("t5_same_cycle_busy9", 32'(busy[9]), 32'd1);
    mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h998;
    cycle();
    idle();
    cycle();
    chk("t5_drained_busy9", 32'(busy[9]), 32'd0);

    // 6: reset with FIFO entries, busy register and a write in flight
    lsu_issue = 1; lsu_issue_rd = 5'd4;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_valid = 1; alu_rd = 5'(1 + i); alu_data = 32'h600 + 32'(i);
      mem_valid = 1; mem_rd = 5'(20 + i); mem_data = 32'h700 + 32'(i);
      cycle();
    end
    chk("t6_pre_fifo", 32'(q.size()), 32'd3);
    chk("t6_pre_busy4", 32'(busy[4]), 32'd1);
    chk("t6_pre_wr", 32'(wr), 32'd1);
    do_reset("t6");
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_no_stale_wr", 32'(wr), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit hold;
      hold = mem_valid && !m_acc;
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd_rst");
        hold = 0;
      end
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      alu_data  = $urandom;
      if (!hold) begin
        mem_valid = $urandom_range(0, 1) == 1;
        mem_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
        mem_data  = $urandom;
      end
      lsu_issue    = ($urandom_range(0, 2) == 0);
      lsu_issue_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_reg_writeback.md
Name: cpu_reg_writeback

Overview:
- Writer side of the CPU register file. Drives the file's single write port (addr_wr, data_wr, wr) from two result sources: the single-cycle ALU path and the variable-latency load (memory) path.
- Buffers load results in a small FIFO whenever the ALU owns the port.
- Keeps a per-register outstanding-load scoreboard that the hazard unit uses to stall dependent instructions.

Parameters:
- MORE_REGISTERS, 1'b1: 1 = registers x1..x31 exist; 0 = only x1..x15 exist. Address width stays 5 bits either way.
- FIFO_DEPTH, 4: load-result FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result valid this cycle
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- mem_ready  out  1  load result accepted when mem_valid && mem_ready
- lsu_issue  in  1  a load to lsu_issue_rd was issued this cycle
- lsu_issue_rd  in  5  destination of the issued load
- lsu_issue_ready  out  1  scoreboard can accept lsu_issue for lsu_issue_rd
- busy  out  32  busy[r] = 1 while loads to r are outstanding; busy[0] = 0 always
- addr_wr  out  5  register file write address
- data_wr  out  32  register file write data
- wr  out  1  register file write enable

Behaviour:
Reset:
- While rst is high, asynchronously: wr=0, addr_wr=0, data_wr=0, FIFO empty, all scoreboard counters 0.
- Therefore busy=0, mem_ready=1, lsu_issue_ready=1.

Valid destinations:
- Register 0 is never a valid destination.
- With MORE_REGISTERS=0, registers 16..31 are also invalid.
- Results to an invalid destination are consumed with no wr pulse. A load result to an invalid destination is still handshaken.
- lsu_issue to an invalid destination is ignored.

Write port:
- wr, addr_wr and data_wr are registered. Any accepted result appears on the port exactly 1 cycle later, for 1 cycle.
- addr_wr and data_wr hold their last value whenever wr=0.

Arbitration, evaluated each cycle:
1. alu_valid with a valid destination: the ALU result is written next cycle. The ALU is never back-pressured.
2. Otherwise, FIFO not empty: pop the head and write it next cycle.
3. Otherwise, mem_valid && mem_ready with a valid destination: bypass, written next cycle without entering the FIFO.
- A load accepted in a cycle where it is not bypassed is pushed to the FIFO tail.
- A push and a pop in the same cycle are both allowed; the count is unchanged.
- Load results retire strictly in acceptance order.

mem_ready:
- mem_ready = !full. It is a combinational function of the registered FIFO count only, with no dependency on the current cycle's inputs.
- When full, the load path must hold mem_valid and its data.

Scoreboard:
- One 2-bit counter per register r, 1..31.
- lsu_issue to a valid r increments cnt[r].
- A load write to r appearing on the write port decrements cnt[r] in that cycle. ALU writes never touch counters.
- An increment and a decrement of the same r in the same cycle leave cnt[r] unchanged.
- busy[r] = (cnt[r] != 0).
- lsu_issue_ready = (cnt[lsu_issue_rd] != 3). It is combinational from lsu_issue_rd and is 1 for invalid destinations.
- lsu_issue while !lsu_issue_ready is ignored; the counter saturates at 3.

Hazards:
- An ALU write to a register with busy=1 is performed as presented; the block does not reorder writes.
- Preventing WAW hazards is the hazard unit's job, using busy.

Reset mid-operation:
- All FIFO contents are discarded.
- Any write that would have appeared in the next cycle is suppressed.

Test Plan:
1. Reset release, then alu_valid, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle wr=1, addr_wr=5, data_wr=0xDEADBEEF; following cycle wr=0; busy=0 throughout.
2. lsu_issue rd=7; 3 cycles later mem_valid rd=7, data=0x12345678 with the FIFO empty and no ALU -> bypass: next cycle wr=1, addr_wr=7; busy[7] is 1 from the cycle after issue and clears in the cycle wr fires.
3. alu_valid held 6 cycles (rd=1..6) while mem_valid streams rd=10..14 -> mem_ready drops after 4 accepts (FIFO_DEPTH=4); the 5th load is held. After the ALU stops, writes to 10,11,12,13,14 appear in order on consecutive cycles.
4. alu_rd=0 and mem_rd=0 with valid data -> no wr pulse; the load is handshaken (mem_ready=1). With MORE_REGISTERS=0, alu_rd=20 -> no wr pulse.
5. Four lsu_issue to rd=9 -> cnt saturates: lsu_issue_ready=0 after the third. Three load results to rd=9 -> busy[9] clears only after the third write. A same-cycle issue and write of rd=9 leaves busy[9]=1.
6. Assert rst with 3 FIFO entries, busy[4]=1 and a write pending -> wr=0 immediately, mem_ready=1, busy=0; no stale writes after release.
